// File: rtl/ask4_slicer.sv
// ---------------------------------------------------------------------------
// ask4_slicer
//   Receive-side 4-ASK symbol slicer. Takes the matched-filter output at the
//   sample rate, keeps one sample per symbol at a selectable phase, and slices
//   it against a reference level r into a 2-bit symbol. r is estimated as the
//   block mean of |y| over 2^AVG_LOG2 captured symbols. The slicer error
//   (y - reconstructed level) is also reported.
//
// Ports
//   sys_clk     : system clock, rising edge
//   reset       : synchronous, active-high
//   sam_clk_en  : one-cycle sample strobe (4 per symbol)
//   sym_clk_en  : symbol strobe, coincident with the first sample strobe
//   phase       : sample index within the symbol to capture (0..3)
//   y_in        : signed matched-filter sample (1s17 at default WIDTH)
//   sym_out     : decision 00=-3a, 01=-a, 10=+a, 11=+3a
//   sym_valid   : one-cycle pulse, sym_out/dec_level/err valid
//   dec_level   : reconstructed level of the decision (+/- r/2, +/- 3r/2)
//   err         : y_sample - dec_level, saturated to WIDTH
//   ref_level   : current reference level r (non-negative)
//   ref_valid   : high once the first estimate block has completed
// ---------------------------------------------------------------------------
module ask4_slicer #(
    parameter int WIDTH    = 18,
    parameter int AVG_LOG2 = 7,
    parameter int REF_INIT = 65536
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic [1:0]              phase,
    input  logic signed [WIDTH-1:0] y_in,
    output logic [1:0]              sym_out,
    output logic                    sym_valid,
    output logic signed [WIDTH-1:0] dec_level,
    output logic signed [WIDTH-1:0] err,
    output logic [WIDTH-1:0]        ref_level,
    output logic                    ref_valid
);

    localparam int AW = WIDTH + AVG_LOG2;   // accumulator width, holds 2^AVG_LOG2 * max|y|
    localparam int EW = WIDTH + 2;          // extended width for level / error arithmetic

    localparam logic [WIDTH-1:0]        REF_INIT_V = WIDTH'(REF_INIT);
    localparam logic [WIDTH-1:0]        REF_FLOOR  = WIDTH'(1);
    localparam logic signed [WIDTH-1:0] SMAX       = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN       = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0]    EMAX       = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0]    EMIN       = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic [AVG_LOG2-1:0]     BLK_ONE    = AVG_LOG2'(1);

    typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

    // Clamp an extended-width signed value into WIDTH bits.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] v);
        if (v > EMAX)
            return SMAX;
        else if (v < EMIN)
            return SMIN;
        else
            return v[WIDTH-1:0];
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t                    r_state;
    logic [1:0]                r_sam_cnt;
    logic [1:0]                r_phase;
    logic [AW-1:0]             r_acc;
    logic [AVG_LOG2-1:0]       r_blk_cnt;
    logic [WIDTH-1:0]          r_ref;
    logic [1:0]                r_sym;
    logic                      r_sym_valid;
    logic signed [WIDTH-1:0]   r_dec;
    logic signed [WIDTH-1:0]   r_err;

    // -----------------------------------------------------------------------
    // Sample counting / phase select
    // -----------------------------------------------------------------------
    logic                      w_boundary;
    logic [1:0]                w_cnt_nxt;
    logic [1:0]                w_phase_eff;
    logic                      w_cap;

    assign w_boundary  = sam_clk_en & sym_clk_en;
    assign w_cnt_nxt   = w_boundary ? 2'd0 : r_sam_cnt + 2'd1;
    // On the boundary strobe the freshly presented phase is the one in force,
    // so phase 0 captures on the very strobe that registers it.
    assign w_phase_eff = w_boundary ? phase : r_phase;
    assign w_cap       = sam_clk_en && (w_cnt_nxt == w_phase_eff);

    // -----------------------------------------------------------------------
    // Slicer (uses the reference level currently in force)
    // -----------------------------------------------------------------------
    logic signed [EW-1:0]      w_y;
    logic signed [EW-1:0]      w_r;
    logic signed [EW-1:0]      w_half;
    logic signed [EW-1:0]      w_three;
    logic signed [EW-1:0]      w_level;
    logic signed [EW-1:0]      w_err_full;
    logic [1:0]                w_sym;

    assign w_y     = {{2{y_in[WIDTH-1]}}, y_in};
    assign w_r     = {2'b00, r_ref};
    assign w_half  = {3'b000, r_ref[WIDTH-1:1]};
    assign w_three = w_r + w_half;

    always_comb begin
        w_sym   = 2'b00;
        w_level = -w_three;
        if (w_y < -w_r) begin
            w_sym   = 2'b00;
            w_level = -w_three;
        end else if (w_y < 0) begin
            w_sym   = 2'b01;
            w_level = -w_half;
        end else if (w_y < w_r) begin
            w_sym   = 2'b10;
            w_level = w_half;
        end else begin
            w_sym   = 2'b11;
            w_level = w_three;
        end
    end

    // Error is formed from the unclamped level so it stays exact even when
    // 3r/2 itself would not fit in WIDTH.
    assign w_err_full = w_y - w_level;

    // -----------------------------------------------------------------------
    // Level estimator
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]          w_abs;
    logic [AW-1:0]             w_sum;
    logic [WIDTH-1:0]          w_mean;
    logic                      w_blk_done;

    // Most negative input maps to the most positive value so |y| fits WIDTH-1 bits.
    always_comb begin
        w_abs = y_in;
        if (y_in == SMIN)
            w_abs = SMAX;
        else if (y_in < 0)
            w_abs = -y_in;
    end

    assign w_sum      = r_acc + AW'(w_abs);
    assign w_mean     = WIDTH'(w_sum >> AVG_LOG2);
    assign w_blk_done = w_cap && (r_blk_cnt == '1);

    // -----------------------------------------------------------------------
    // FSM: ACQ until the first estimate block completes, then TRACK forever
    // -----------------------------------------------------------------------
    state_t                    w_state_nxt;

    always_ff @(posedge sys_clk) begin
        if (reset)
            r_state <= ACQ;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACQ:     if (w_blk_done) w_state_nxt = TRACK;
            TRACK:   w_state_nxt = TRACK;
            default: w_state_nxt = ACQ;
        endcase
    end

    always_comb begin
        ref_valid = (r_state == TRACK);
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_sam_cnt   <= 2'd0;
            r_phase     <= 2'd0;
            r_acc       <= '0;
            r_blk_cnt   <= '0;
            r_ref       <= REF_INIT_V;
            r_sym       <= 2'b00;
            r_sym_valid <= 1'b0;
            r_dec       <= '0;
            r_err       <= '0;
        end else begin
            r_sym_valid <= w_cap;

            if (sam_clk_en)
                r_sam_cnt <= w_cnt_nxt;
            if (w_boundary)
                r_phase <= phase;

            if (w_cap) begin
                r_sym <= w_sym;
                r_dec <= sat(w_level);
                r_err <= sat(w_err_full);

                if (w_blk_done) begin
                    // The completing symbol was sliced with the old r above.
                    r_acc     <= '0;
                    r_blk_cnt <= '0;
                    r_ref     <= (w_mean == '0) ? REF_FLOOR : w_mean;
                end else begin
                    r_acc     <= w_sum;
                    r_blk_cnt <= r_blk_cnt + BLK_ONE;
                end
            end
        end
    end

    assign sym_out   = r_sym;
    assign sym_valid = r_sym_valid;
    assign dec_level = r_dec;
    assign err       = r_err;
    assign ref_level = r_ref;

endmodule

// File: tb/tb_ask4_slicer.sv
// ---------------------------------------------------------------------------
// tb_ask4_slicer
//   Directed bench for ask4_slicer. Symbols are sent as 4 sample strobes, each
//   followed by an idle cycle; any sym_valid seen during idle cycles counts as
//   a stray pulse. Expected values are hand-computed from the slicing rules.
// ---------------------------------------------------------------------------
module tb_ask4_slicer;

    logic               sys_clk = 1'b0;
    logic               reset = 1'b1;
    logic               sam_clk_en = 1'b0;
    logic               sym_clk_en = 1'b0;
    logic [1:0]         phase = 2'd0;
    logic signed [17:0] y_in = '0;
    logic [1:0]         sym_out;
    logic               sym_valid;
    logic signed [17:0] dec_level;
    logic signed [17:0] err;
    logic [17:0]        ref_level;
    logic               ref_valid;

    ask4_slicer #(.WIDTH(18), .AVG_LOG2(7), .REF_INIT(65536)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .sam_clk_en(sam_clk_en),
        .sym_clk_en(sym_clk_en),
        .phase     (phase),
        .y_in      (y_in),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .dec_level (dec_level),
        .err       (err),
        .ref_level (ref_level),
        .ref_valid (ref_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Results recorded at the sym_valid pulse of the last symbol sent.
    int nv, nbad;
    int g_sym, g_dec, g_err, g_ref, g_rv;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset      = 1'b1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        reset = 1'b0;
    endtask

    // Sends one symbol; phase input switches to chg_ph just before sample chg_k.
    task automatic send_sym(input int y0, input int y1, input int y2, input int y3,
                            input bit use_sym, input int chg_k, input logic [1:0] chg_ph);
        int ys[4];
        ys = '{y0, y1, y2, y3};
        nv = 0;
        nbad = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == chg_k) phase = chg_ph;
            sam_clk_en = 1'b1;
            sym_clk_en = use_sym && (k == 0);
            y_in       = 18'(ys[k]);
            @(posedge sys_clk);
            #1;
            if (sym_valid) begin
                nv++;
                g_sym = int'(sym_out);
                g_dec = int'(dec_level);
                g_err = int'(err);
                g_ref = int'(ref_level);
                g_rv  = int'(ref_valid);
            end
            sam_clk_en = 1'b0;
            sym_clk_en = 1'b0;
            y_in       = 18'sd77777;
            @(posedge sys_clk);
            #1;
            if (sym_valid) nbad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sam_clk_en = 1'($urandom);
            sym_clk_en = 1'($urandom);
            y_in       = 18'($urandom);
            phase      = 2'($urandom);
            @(posedge sys_clk);
            #1;
            checks++;
            if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid got %b want 0", sym_valid); end
        end
        checks++;
        if (sym_out !== 2'b00 || dec_level !== 18'sd0 || err !== 18'sd0) begin
            errors++; $display("FAIL reset_outputs got sym %b dec %0d err %0d want 0 0 0", sym_out, dec_level, err);
        end
        checks++;
        if (ref_level !== 18'd65536 || ref_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ref got %0d/%b want 65536/0", ref_level, ref_valid);
        end
        reset = 1'b0; sam_clk_en = 1'b0; sym_clk_en = 1'b0; phase = 2'd0;
        @(posedge sys_clk);
        #1;
        // No sym_clk_en yet: count runs 1,2,3,0 so the 4th strobe is captured.
        send_sym(-1000, -2000, -3000, 98304, 1'b0, -1, 2'd0);
        checks++;
        if (nv !== 1 || nbad !== 0 || g_sym !== 3 || g_err !== 0) begin
            errors++; $display("FAIL nosym_capture got nv %0d stray %0d sym %0d err %0d want 1 0 3 0", nv, nbad, g_sym, g_err);
        end
    endtask

    task automatic test_slice_acq();
        int ys[8]   = '{-98304, -32768, 32768, 98304, -65536, -1, 0, 65536};
        int esym[8] = '{0, 1, 2, 3, 1, 1, 2, 3};
        int edec[8] = '{-98304, -32768, 32768, 98304, -32768, -32768, 32768, 98304};
        int eerr[8] = '{0, 0, 0, 0, -32768, 32767, -32768, -32768};
        phase = 2'd0;
        for (int i = 0; i < 8; i++) begin
            send_sym(ys[i], 5555, -5555, 77777, 1'b1, -1, 2'd0);
            checks++;
            if (nv !== 1 || nbad !== 0) begin
                errors++; $display("FAIL slice%0d_valid got %0d pulses %0d stray want 1 0", i, nv, nbad);
            end
            checks++;
            if (g_sym !== esym[i] || g_dec !== edec[i] || g_err !== eerr[i]) begin
                errors++; $display("FAIL slice%0d got sym %0d dec %0d err %0d want %0d %0d %0d",
                                   i, g_sym, g_dec, g_err, esym[i], edec[i], eerr[i]);
            end
        end
    endtask

    task automatic test_phase();
        // {chg_k, chg_ph, expected err}; r=65536 so captured y -> sym 10, err = y - 32768
        int ck[5]   = '{-1, 1, -1, 3, -1};
        int cp[5]   = '{0, 3, 0, 0, 0};
        int eerr[5] = '{-30768, -30768, -29768, -29768, -32768};
        phase = 2'd2;
        for (int i = 0; i < 5; i++) begin
            send_sym(0, 1000, 2000, 3000, 1'b1, ck[i], 2'(cp[i]));
            checks++;
            if (nv !== 1 || nbad !== 0 || g_sym !== 2 || g_err !== eerr[i]) begin
                errors++; $display("FAIL phase%0d got nv %0d stray %0d sym %0d err %0d want 1 0 2 %0d",
                                   i, nv, nbad, g_sym, g_err, eerr[i]);
            end
        end
    endtask

    task automatic test_estimator();
        int bad = 0;
        do_reset();
        phase = 2'd0;
        for (int s = 1; s <= 128; s++) begin
            send_sym(40000, 0, 0, 0, 1'b1, -1, 2'd0);
            if (nv !== 1 || nbad !== 0) bad++;
            if (s == 127) begin
                checks++;
                if (g_ref !== 65536 || g_rv !== 0) begin
                    errors++; $display("FAIL est_127 got ref %0d valid %0d want 65536 0", g_ref, g_rv);
                end
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL est_pulses got %0d bad symbols want 0", bad); end
        checks++;
        if (g_ref !== 40000 || g_rv !== 1) begin
            errors++; $display("FAIL est_128_ref got ref %0d valid %0d want 40000 1", g_ref, g_rv);
        end
        checks++;
        if (g_sym !== 2 || g_dec !== 32768 || g_err !== 7232) begin
            errors++; $display("FAIL est_128_slice got %0d %0d %0d want 2 32768 7232", g_sym, g_dec, g_err);
        end
        send_sym(39999, 0, 0, 0, 1'b1, -1, 2'd0);
        checks++;
        if (g_sym !== 2 || g_dec !== 20000 || g_err !== 19999) begin
            errors++; $display("FAIL est_39999 got %0d %0d %0d want 2 20000 19999", g_sym, g_dec, g_err);
        end
        send_sym(40000, 0, 0, 0, 1'b1, -1, 2'd0);
        checks++;
        if (g_sym !== 3 || g_dec !== 60000 || g_err !== -20000) begin
            errors++; $display("FAIL est_40000 got %0d %0d %0d want 3 60000 -20000", g_sym, g_dec, g_err);
        end
    endtask

    task automatic test_floor_sat_reset();
        do_reset();
        phase = 2'd0;
        for (int s = 1; s <= 128; s++) send_sym(0, 9, 9, 9, 1'b1, -1, 2'd0);
        checks++;
        if (g_ref !== 1 || g_rv !== 1) begin
            errors++; $display("FAIL floor got ref %0d valid %0d want 1 1", g_ref, g_rv);
        end
        // r=1: level -3r/2 = -1, err = -131072 + 1
        send_sym(-131072, 0, 0, 0, 1'b1, -1, 2'd0);
        checks++;
        if (g_sym !== 0 || g_dec !== -1 || g_err !== -131071) begin
            errors++; $display("FAIL minval got %0d %0d %0d want 0 -1 -131071", g_sym, g_dec, g_err);
        end
        send_sym(131071, 0, 0, 0, 1'b1, -1, 2'd0);
        checks++;
        if (g_sym !== 3 || g_dec !== 1 || g_err !== 131070) begin
            errors++; $display("FAIL maxval got %0d %0d %0d want 3 1 131070", g_sym, g_dec, g_err);
        end
        for (int s = 0; s < 58; s++) send_sym(40000, 0, 0, 0, 1'b1, -1, 2'd0);
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        checks++;
        if (ref_level !== 18'd65536 || ref_valid !== 1'b0 || sym_out !== 2'b00) begin
            errors++; $display("FAIL midreset got ref %0d valid %b sym %b want 65536 0 00", ref_level, ref_valid, sym_out);
        end
        reset = 1'b0;
        for (int s = 1; s <= 128; s++) begin
            send_sym(20000, 0, 0, 0, 1'b1, -1, 2'd0);
            if (s == 127) begin
                checks++;
                if (g_ref !== 65536 || g_rv !== 0) begin
                    errors++; $display("FAIL newblk_127 got ref %0d valid %0d want 65536 0", g_ref, g_rv);
                end
            end
        end
        checks++;
        if (g_ref !== 20000 || g_rv !== 1 || g_err !== -12768) begin
            errors++; $display("FAIL newblk_128 got ref %0d valid %0d err %0d want 20000 1 -12768", g_ref, g_rv, g_err);
        end
    endtask

    initial begin
        test_reset();
        test_slice_acq();
        test_phase();
        test_estimator();
        test_floor_sat_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
